seg_scan_driver: RTL and testbench

- Consumer side of the packed-BCD countdown buses (two 8-bit buses, tens nibble in [7:4], units nibble in [3:0]) produced by the traffic-light countdown counters.
- Drives one shared, time-multiplexed 4-digit common-anode 7-segment display. Decodes the special codes, suppresses leading zeros and blinks the pair being edited in set mode.
- Sits between the two countdown counters and the board pins. Runs on the 125 MHz system clock; no divided clock is used.

---
 rtl/seg_scan_driver_if.sv | 50 +++++
 rtl/seg_scan_driver.sv | 247 ++++++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
// Bus between the two traffic-light countdown counters and the multiplexed
// 7-segment display driver.
//
// Signals:
//   bcd1       [7:0]  packed BCD for display pair 1 (highway), tens in [7:4]
//   bcd2       [7:0]  packed BCD for display pair 2 (railway), tens in [7:4]
//   blink_en   [1:0]  bit i = 1 blinks pair i+1
//   lz_blank          1 = blank a tens digit of 0
//   seg_n      [6:0]  active-low segments {g,f,e,d,c,b,a}
//   an_n       [3:0]  active-low digit enables, at most one low
//   frame_tick        one-cycle pulse at each frame start
//
// Modports:
//   master  countdown / board side: drives the BCD and display controls,
//           observes the display pins
//   slave   the display driver: consumes the BCD, drives the display pins
// -----------------------------------------------------------------------------
interface seg_scan_driver_if;

    logic [7:0] bcd1;
    logic [7:0] bcd2;
    logic [1:0] blink_en;
    logic       lz_blank;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       frame_tick;

    modport master (
        output bcd1,
        output bcd2,
        output blink_en,
        output lz_blank,
        input  seg_n,
        input  an_n,
        input  frame_tick
    );

    modport slave (
        input  bcd1,
        input  bcd2,
        input  blink_en,
        input  lz_blank,
        output seg_n,
        output an_n,
        output frame_tick
    );

endinterface : seg_scan_driver_if

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexes one 4-digit common-anode 7-segment display between the two
// packed-BCD countdown buses. Digit slots are SCAN_DIV system clocks long and
// run in the order 0,1,2,3 (pair 1 units, pair 1 tens, pair 2 units, pair 2
// tens). Both buses are captured once per frame so a frame never shows a mix
// of old and new counter values. Handles the dash / blank special codes,
// optional leading-zero suppression of the tens digits and blinking of a pair
// while it is being edited.
//
// Ports:
//   clk     system clock (125 MHz), no divided clocks
//   rst_n   asynchronous active-low reset, release sampled on clk
//   bus     seg_scan_driver_if.slave
//             in : bcd1, bcd2, blink_en, lz_blank
//             out: seg_n, an_n, frame_tick (all registered)
//
// Parameters:
//   SCAN_DIV      system clocks per digit slot, 2 or more
//   BLINK_FRAMES  frames per blink-phase toggle, 1 or more
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int SCAN_DIV     = 31250,
    parameter int BLINK_FRAMES = 250
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave bus
);

    // -------------------------------------------------------------------------
    // Derived sizes and constants
    // -------------------------------------------------------------------------
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    // One cycle before the slot tick; lets frame_tick be a registered pulse
    // that is high exactly in the slot-tick cycle.
    localparam logic [PW-1:0] PRESC_PRE  = PW'(SCAN_DIV - 2);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Nibble to active-low {g,f,e,d,c,b,a}. A is the dash used in night mode,
    // B..F are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h3F;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Active-low one-cold anode pattern for a digit index.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = 4'b1110;
            2'd1:    an = 4'b1101;
            2'd2:    an = 4'b1011;
            2'd3:    an = 4'b0111;
            default: an = 4'b1111;
        endcase
        return an;
    endfunction

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
    logic          slot_tick_s;
    logic          pre_tick_s;

    // digit_r is the digit that the next slot tick will put on the display.
    // Reset value 0 makes the very first slot after reset a frame start.
    logic [1:0]    digit_r;
    logic [1:0]    digit_nxt_s;
    logic          frame_start_s;

    logic [7:0]    snap1_r;
    logic [7:0]    snap2_r;
    logic [7:0]    snap1_nxt_s;
    logic [7:0]    snap2_nxt_s;

    logic [BW-1:0] blink_cnt_r;
    logic [BW-1:0] blink_cnt_nxt_s;
    logic          blink_phase_r;
    logic          blink_phase_nxt_s;

    logic [7:0]    pair_bcd_s;
    logic [3:0]    nibble_s;
    logic          blink_off_s;
    logic          lz_off_s;

    logic [6:0]    seg_r;
    logic [6:0]    seg_nxt_s;
    logic [3:0]    an_r;
    logic [3:0]    an_nxt_s;
    logic          frame_tick_r;
    logic          frame_tick_nxt_s;

    // -------------------------------------------------------------------------
    // Slot timebase: prescaler, slot tick and digit index advance
    // -------------------------------------------------------------------------

    // Prescaler wrap generates the slot tick; the digit index moves with it.
    always_comb begin
        presc_nxt_s = presc_r;
        digit_nxt_s = digit_r;
        slot_tick_s = 1'b0;
        if (presc_r == PRESC_LAST) begin
            slot_tick_s = 1'b1;
            presc_nxt_s = {PW{1'b0}};
            digit_nxt_s = digit_r + 2'd1;
        end else begin
            presc_nxt_s = presc_r + PW'(1);
        end
    end

    assign pre_tick_s    = (presc_r == PRESC_PRE);
    assign frame_start_s = slot_tick_s && (digit_r == 2'd0);

    // digit_r is stable from the pre-tick cycle through the tick cycle, so
    // this registers high exactly during the frame-start slot tick.
    assign frame_tick_nxt_s = pre_tick_s && (digit_r == 2'd0);

    // -------------------------------------------------------------------------
    // Frame snapshot and blink phase
    // -------------------------------------------------------------------------

    // Capture both buses and step the blink frame counter at each frame start.
    always_comb begin
        snap1_nxt_s       = snap1_r;
        snap2_nxt_s       = snap2_r;
        blink_cnt_nxt_s   = blink_cnt_r;
        blink_phase_nxt_s = blink_phase_r;
        if (frame_start_s) begin
            snap1_nxt_s = bus.bcd1;
            snap2_nxt_s = bus.bcd2;
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_nxt_s   = {BW{1'b0}};
                blink_phase_nxt_s = ~blink_phase_r;
            end else begin
                blink_cnt_nxt_s   = blink_cnt_r + BW'(1);
            end
        end else begin
            snap1_nxt_s       = snap1_r;
            snap2_nxt_s       = snap2_r;
        end
    end

    // -------------------------------------------------------------------------
    // Digit selection and output pattern
    // -------------------------------------------------------------------------
    // The next-state snapshot and blink phase are used on purpose: on a frame
    // start they already hold the freshly captured values, so digit 0 of the
    // new frame shows the new snapshot and the new blink phase.
    assign pair_bcd_s  = digit_r[1] ? snap2_nxt_s : snap1_nxt_s;
    assign nibble_s    = digit_r[0] ? pair_bcd_s[7:4] : pair_bcd_s[3:0];
    assign blink_off_s = blink_phase_nxt_s && bus.blink_en[digit_r[1]];
    assign lz_off_s    = digit_r[0] && bus.lz_blank && (nibble_s == 4'h0);

    // Build the pattern for the digit entering its slot; a disabled digit
    // keeps its slot dark so the others keep their brightness.
    always_comb begin
        seg_nxt_s = seg_r;
        an_nxt_s  = an_r;
        if (slot_tick_s) begin
            if (blink_off_s || lz_off_s) begin
                seg_nxt_s = SEG_OFF;
                an_nxt_s  = AN_OFF;
            end else begin
                seg_nxt_s = seg_decode(nibble_s);
                an_nxt_s  = an_select(digit_r);
            end
        end else begin
            seg_nxt_s = seg_r;
            an_nxt_s  = an_r;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------

    // Timebase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PW{1'b0}};
            digit_r <= 2'd0;
        end else begin
            presc_r <= presc_nxt_s;
            digit_r <= digit_nxt_s;
        end
    end

    // Frame snapshot and blink registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap1_r       <= 8'h00;
            snap2_r       <= 8'h00;
            blink_cnt_r   <= {BW{1'b0}};
            blink_phase_r <= 1'b0;
        end else begin
            snap1_r       <= snap1_nxt_s;
            snap2_r       <= snap2_nxt_s;
            blink_cnt_r   <= blink_cnt_nxt_s;
            blink_phase_r <= blink_phase_nxt_s;
        end
    end

    // Display pin registers; reset forces the display dark at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r        <= SEG_OFF;
            an_r         <= AN_OFF;
            frame_tick_r <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            an_r         <= an_nxt_s;
            frame_tick_r <= frame_tick_nxt_s;
        end
    end

    assign bus.seg_n      = seg_r;
    assign bus.an_n       = an_r;
    assign bus.frame_tick = frame_tick_r;

endmodule : seg_scan_driver

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Directed and randomized stimulus for seg_scan_driver with SCAN_DIV=4 and
// BLINK_FRAMES=2. A reference model works in terms of slot number since
// reset: slot n shows digit n%4 of frame n/4, the blink phase of frame f is
// ((f+1)/BLINK_FRAMES)%2, and its expected pins are pushed into a scoreboard
// queue tagged with the cycle they become visible. A monitor on the falling
// edge pops due entries and compares the display pins and frame_tick.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int SD = 4;
    localparam int BF = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t       sb_q [$];
    int         k       = 0;   // rising edges since reset release
    int         n_vec   = 0;
    int         n_err   = 0;
    logic [7:0] m_snap1 = 8'h00;
    logic [7:0] m_snap2 = 8'h00;
    logic [6:0] glyph [16];

    initial begin
        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h3F; glyph[11] = 7'h7F;
        glyph[12] = 7'h7F; glyph[13] = 7'h7F; glyph[14] = 7'h7F; glyph[15] = 7'h7F;
    end

    // Reference model: on every slot boundary predict what the slot shows.
    always @(posedge clk) begin : predictor
        int         n;
        int         d;
        int         f;
        int         phase;
        logic [7:0] pv;
        logic [3:0] nib;
        logic       off;
        exp_t       pe;
        if (!rst_n) begin
            k = 0;
        end else begin
            k = k + 1;
            if (k % SD == 0) begin
                n = k / SD - 1;
                d = n % 4;
                f = n / 4;
                if (d == 0) begin
                    m_snap1 = bus.bcd1;
                    m_snap2 = bus.bcd2;
                end
                phase = ((f + 1) / BF) % 2;
                pv    = (d < 2) ? m_snap1 : m_snap2;
                nib   = (d % 2 == 1) ? pv[7:4] : pv[3:0];
                off   = ((phase == 1) && bus.blink_en[d / 2]) ||
                        ((d % 2 == 1) && bus.lz_blank && (nib == 4'h0));
                pe.due = k;
                if (off) begin
                    pe.an  = 4'hF;
                    pe.seg = 7'h7F;
                end else begin
                    pe.an    = 4'hF;
                    pe.an[d] = 1'b0;
                    pe.seg   = glyph[nib];
                end
                sb_q.push_back(pe);
            end
        end
    end

    // Monitor: retire due predictions and compare on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [3:0] cur_an;
        logic [6:0] cur_seg;
        logic       exp_ft;
        if (!rst_n) begin
            sb_q.delete();
            cur_an  = 4'hF;
            cur_seg = 7'h7F;
            exp_ft  = 1'b0;
        end else begin
            while (sb_q.size() > 0 && sb_q[0].due <= k) begin
                e       = sb_q.pop_front();
                cur_an  = e.an;
                cur_seg = e.seg;
            end
            exp_ft = ((k + 1) % SD == 0) && ((((k + 1) / SD) - 1) % 4 == 0);
        end
        n_vec = n_vec + 1;
        if (bus.an_n !== cur_an || bus.seg_n !== cur_seg) begin
            n_err = n_err + 1;
            $display("FAIL pins t=%0t k=%0d: an_n=%h seg_n=%h, required an_n=%h seg_n=%h",
                     $time, k, bus.an_n, bus.seg_n, cur_an, cur_seg);
        end
        n_vec = n_vec + 1;
        if (bus.frame_tick !== exp_ft) begin
            n_err = n_err + 1;
            $display("FAIL frame_tick t=%0t k=%0d: got %b, required %b",
                     $time, k, bus.frame_tick, exp_ft);
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(input int cycles);
        rst_n = 1'b0;
        run(cycles);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] pick_bcd();
        logic [7:0] sp [8];
        logic [7:0] v;
        sp[0] = 8'hAA; sp[1] = 8'h88; sp[2] = 8'h00; sp[3] = 8'h05;
        sp[4] = 8'hBF; sp[5] = 8'h0A; sp[6] = 8'h90; sp[7] = 8'hA0;
        case ($urandom_range(0, 3))
            0:       v = 8'($urandom_range(0, 255));
            1:       v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            2:       v = sp[$urandom_range(0, 7)];
            default: v = {4'h0, 4'($urandom_range(0, 9))};
        endcase
        return v;
    endfunction

    initial begin
        bus.bcd1     = 8'h27;
        bus.bcd2     = 8'h10;
        bus.blink_en = 2'b00;
        bus.lz_blank = 1'b0;
        #1 rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;

        // Basic scan, then a mid-frame change.
        run(38);
        bus.bcd1 = 8'h26;
        run(40);
        // Special codes.
        bus.bcd1 = 8'hAA;
        bus.bcd2 = 8'h88;
        run(32);
        bus.bcd1 = 8'hBF;
        run(32);
        // Leading-zero suppression.
        bus.lz_blank = 1'b1;
        bus.bcd1     = 8'h05;
        run(32);
        bus.bcd1 = 8'h00;
        run(32);
        // Blink pair 1 only.
        bus.lz_blank = 1'b0;
        bus.bcd1     = 8'h27;
        bus.blink_en = 2'b01;
        run(160);
        // Reset in the middle of a frame.
        bus.blink_en = 2'b00;
        run(9);
        pulse_reset(2);
        run(40);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.bcd1 = pick_bcd();
            if ($urandom_range(0, 7) == 0) bus.bcd2 = pick_bcd();
            if ($urandom_range(0, 31) == 0) bus.blink_en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) bus.lz_blank = 1'($urandom_range(0, 1));
            if (i == 1700) pulse_reset($urandom_range(1, 5));
            run(1);
        end
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seg_scan_driver
